// File: rtl/taillight_sequencer.sv
`timescale 1ns/1ps
// Purpose: Thunderbird-style turn/hazard taillight sequencer with switch synchronizers and step prescaler.
// Latency: switch to lamp is at most 2 + TICK_DIV cycles; lights/state_code are registered and change only on tick edges.
// Backpressure: none; free-running prescaler, the FSM advances once per tick.
//
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   left/right/hazard - raw switches, asynchronous to clk
//   lights     - {LC, LB, LA, RA, RB, RC}, 1 = lamp on
//   state_code - current FSM state (0..7), drives the seven-segment decoder
//   tick       - one-cycle step strobe
module taillight_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [5:0] lights,
  output logic [2:0] state_code,
  output logic       tick
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_div_check
    $error("taillight_sequencer: CLK_HZ / STEP_HZ must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  state_t           state;
  logic [2:0]       sync_meta;
  logic [2:0]       sync_out;
  logic [CNT_W-1:0] cnt;
  logic             l_s;
  logic             r_s;
  logic             h_s;

  // Two-flop synchronizers, bit order {left, right, hazard}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= {left, right, hazard};
      sync_out  <= sync_meta;
    end
  end

  assign l_s = sync_out[2];
  assign r_s = sync_out[1];
  assign h_s = sync_out[0];

  // Free-running prescaler; tick marks its last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

  function automatic state_t next_state(input state_t s, input logic l, input logic r,
                                        input logic h);
    state_t n;
    n = s;
    // Hazard (or both turn switches) preempts anything except HAZ itself,
    // which must fall back to IDLE so the lamps flash.
    if (s != HAZ && (h || (l && r))) begin
      n = HAZ;
    end else begin
      case (s)
        HAZ:     n = IDLE;
        IDLE:    n = l ? L1 : (r ? R1 : IDLE);
        L1:      n = L2;
        L2:      n = L3;
        L3:      n = IDLE;
        R1:      n = R2;
        R2:      n = R3;
        R3:      n = IDLE;
        default: n = IDLE;
      endcase
    end
    return n;
  endfunction

  function automatic logic [5:0] lamp_pattern(input state_t s);
    logic [5:0] p;
    p = 6'b000000;
    case (s)
      L1:      p = 6'b001000;
      L2:      p = 6'b011000;
      L3:      p = 6'b111000;
      R1:      p = 6'b000100;
      R2:      p = 6'b000110;
      R3:      p = 6'b000111;
      HAZ:     p = 6'b111111;
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  // Lights are decoded from the next state so they land on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      lights <= 6'b000000;
    end else if (tick) begin
      state  <= next_state(state, l_s, r_s, h_s);
      lights <= lamp_pattern(next_state(state, l_s, r_s, h_s));
    end
  end

  assign state_code = state;

endmodule
